// File: rtl/ewrapper_io_tx_ser_pkg.sv
// Shared eLink constants and types for the transmit serializer and its lane shifters.
package ewrapper_pkg;

    localparam int ELINK_NLANES = 9;
    localparam int ELINK_NPHASE = 4;
    localparam int ELINK_WORD_W = 72;

    localparam logic [ELINK_WORD_W-1:0] ELINK_IDLE_WORD = 72'd0;

    typedef logic [1:0] phase_t;

endpackage

// File: rtl/ewrapper_io_tx_ser_if.sv
// Word handshake and per-lane serial outputs of the eLink transmit serializer.
interface ewrapper_io_tx_ser_if
    import ewrapper_pkg::*;
#(
    parameter int NLANES = ELINK_NLANES
);

    logic [8*NLANES-1:0] DATA_FROM_DEVICE;
    logic                DATA_VALID;
    logic                DATA_READY;
    logic [NLANES-1:0]   DATA_EVEN;
    logic [NLANES-1:0]   DATA_ODD;
    logic                FRAME_START;
    logic                TX_BUSY;

    modport master (
        output DATA_FROM_DEVICE, DATA_VALID,
        input  DATA_READY, DATA_EVEN, DATA_ODD, FRAME_START, TX_BUSY
    );

    modport slave (
        input  DATA_FROM_DEVICE, DATA_VALID,
        output DATA_READY, DATA_EVEN, DATA_ODD, FRAME_START, TX_BUSY
    );

endinterface

// File: rtl/ewrapper_io_tx_ser_lane.sv
// One lane: 8-bit load / shift-by-2 register, MSB pair feeds the ODDR D1/D2 inputs.
// ETX_INVERT_EN inverts the lane data as it enters the register.
module ewrapper_tx_lane_ser (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] word_i,
    output logic       even_o,
    output logic       odd_o
);

`ifdef ETX_INVERT_EN
    localparam logic [7:0] POL_MASK = 8'hFF;
`else
    localparam logic [7:0] POL_MASK = 8'h00;
`endif

    logic [7:0] shift_q, shift_d;

    always_comb begin
        shift_d = {shift_q[5:0], 2'b00};
        if (load_i) begin
            shift_d = word_i ^ POL_MASK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign even_o = shift_q[7];
    assign odd_o  = shift_q[6];

endmodule

// File: rtl/ewrapper_io_tx_ser.sv
// eLink transmit serializer: phase counter, one-entry pending buffer and handshake,
// driving NLANES lane shifters. Build option ETX_INVERT_EN selects inverted lane polarity.
module ewrapper_io_tx_ser
    import ewrapper_pkg::*;
#(
    parameter int NLANES = ELINK_NLANES,
    parameter int NPHASE = ELINK_NPHASE
) (
    input  logic                  CLK_IN,
    input  logic                  IO_RESET_N,
    ewrapper_io_tx_ser_if.slave   tx
);

    localparam int     WORD_W     = 8 * NLANES;
    localparam phase_t PHASE_LOAD = phase_t'(NPHASE - 1);

    phase_t              phase_q, phase_d;
    logic [WORD_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                frame_q;
    logic                busy_q;

    logic                load_edge;
    logic                ready;
    logic                accept;
    logic [WORD_W-1:0]   lane_word;
    logic [NLANES-1:0]   even_w;
    logic [NLANES-1:0]   odd_w;

    assign load_edge = (phase_q == PHASE_LOAD);
    // The pending slot frees up on the load edge, so a new word may land there in the same cycle.
    assign ready     = IO_RESET_N & (~pend_vld_q | load_edge);
    assign accept    = tx.DATA_VALID & ready;
    assign lane_word = pend_vld_q ? pend_q : ELINK_IDLE_WORD[WORD_W-1:0];

    always_comb begin
        phase_d    = load_edge ? '0 : phase_q + 2'd1;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (accept) begin
            pend_d     = tx.DATA_FROM_DEVICE;
            pend_vld_d = 1'b1;
        end else if (load_edge) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!IO_RESET_N) begin
            phase_q    <= PHASE_LOAD;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= (phase_d == '0);
            if (load_edge) begin
                busy_q <= pend_vld_q;
            end
        end
    end

    for (genvar n = 0; n < NLANES; n++) begin : g_lane
        ewrapper_tx_lane_ser u_lane (
            .clk_i  (CLK_IN),
            .rst_ni (IO_RESET_N),
            .load_i (load_edge),
            .word_i (lane_word[8*n +: 8]),
            .even_o (even_w[n]),
            .odd_o  (odd_w[n])
        );
    end

    assign tx.DATA_READY  = ready;
    assign tx.DATA_EVEN   = even_w;
    assign tx.DATA_ODD    = odd_w;
    assign tx.FRAME_START = frame_q;
    assign tx.TX_BUSY     = busy_q;

endmodule

// File: tb/tb_ewrapper_io_tx_ser.sv
// Directed bench for ewrapper_io_tx_ser: idle framing, single word, streaming,
// back-to-back accept at the load edge and mid-frame reset.
module tb_ewrapper_io_tx_ser;
    import ewrapper_pkg::*;

`ifdef ETX_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ewrapper_io_tx_ser_if bus ();

    ewrapper_io_tx_ser dut (
        .CLK_IN     (clk),
        .IO_RESET_N (rst_n),
        .tx         (bus)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mkword(input int k);
        logic [71:0] w;
        for (int n = 0; n < 9; n++) begin
            w[8*n +: 8] = 8'(k * 16 + n * 3 + 1);
        end
        return w;
    endfunction

    // Collects four cycles starting at a phase-0 cycle and reassembles the word.
    task automatic rx_frame(output logic [71:0] w, output logic [3:0] bv, output logic [3:0] fs);
        w  = '0;
        bv = '0;
        fs = '0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 9; n++) begin
                w[8*n + 7 - 2*k] = bus.DATA_EVEN[n] ^ INV;
                w[8*n + 6 - 2*k] = bus.DATA_ODD[n] ^ INV;
            end
            bv[k] = bus.TX_BUSY;
            fs[k] = bus.FRAME_START;
            step();
        end
    endtask

    logic [71:0] rw;
    logic [3:0]  rb;
    logic [3:0]  rf;
    logic [3:0]  sb;
    logic [1:0]  pairs [4];
    logic        exp_rdy;
    logic        exp_b;
    int          acc;
    int          rxi;

    initial begin
        pairs[0] = 2'b10; pairs[1] = 2'b01; pairs[2] = 2'b01; pairs[3] = 2'b10;

        // Reset state
        rst_n = 1'b0;
        bus.DATA_VALID = 1'b0;
        bus.DATA_FROM_DEVICE = '0;
        repeat (3) step();
        chk("rst_even",  72'(bus.DATA_EVEN),   72'(9'h000));
        chk("rst_odd",   72'(bus.DATA_ODD),    72'(9'h000));
        chk("rst_frame", 72'(bus.FRAME_START), 72'(1'b0));
        chk("rst_busy",  72'(bus.TX_BUSY),     72'(1'b0));
        chk("rst_ready", 72'(bus.DATA_READY),  72'(1'b0));

        rst_n = 1'b1;
        #1;
        chk("rel_ready", 72'(bus.DATA_READY), 72'(1'b1));

        // Idle frames: FRAME_START on cycles 1, 5, 9
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("idle_frame", 72'(bus.FRAME_START), 72'(i % 4 == 1));
            chk("idle_even",  72'(bus.DATA_EVEN),   72'({9{INV}}));
            chk("idle_odd",   72'(bus.DATA_ODD),    72'({9{INV}}));
            chk("idle_busy",  72'(bus.TX_BUSY),     72'(1'b0));
        end

        // Single word accepted in phase 1
        step();
        step();
        bus.DATA_VALID = 1'b1;
        bus.DATA_FROM_DEVICE = 72'hA5_5A_FF_00_81_7E_C3_3C_96;
        #1;
        chk("single_ready_ph1", 72'(bus.DATA_READY), 72'(1'b1));
        step();
        bus.DATA_VALID = 1'b0;
        bus.DATA_FROM_DEVICE = '0;
        #1;
        chk("single_ready_ph2", 72'(bus.DATA_READY), 72'(1'b0));
        step();
        chk("single_ready_ph3", 72'(bus.DATA_READY), 72'(1'b1));
        chk("single_busy_pre",  72'(bus.TX_BUSY),    72'(1'b0));
        step();
        for (int k = 0; k < 4; k++) begin
            chk("single_lane0", 72'({bus.DATA_EVEN[0] ^ INV, bus.DATA_ODD[0] ^ INV}), 72'(pairs[k]));
            chk("single_busy",  72'(bus.TX_BUSY), 72'(1'b1));
            chk("single_frame", 72'(bus.FRAME_START), 72'(k == 0));
            step();
        end
        chk("single_busy_post", 72'(bus.TX_BUSY),   72'(1'b0));
        chk("single_even_post", 72'(bus.DATA_EVEN), 72'({9{INV}}));

        // Streaming: valid held for 40 cycles starting at a phase-0 cycle
        acc = 0;
        rxi = 0;
        sb  = '0;
        rw  = '0;
        for (int i = 0; i < 52; i++) begin
            bus.DATA_VALID = (i < 40);
            bus.DATA_FROM_DEVICE = mkword(acc);
            #1;
            exp_rdy = (i == 0) || (i >= 44) || (i % 4 == 3);
            chk("stream_ready", 72'(bus.DATA_READY), 72'(exp_rdy));
            for (int n = 0; n < 9; n++) begin
                rw[8*n + 7 - 2*(i % 4)] = bus.DATA_EVEN[n] ^ INV;
                rw[8*n + 6 - 2*(i % 4)] = bus.DATA_ODD[n] ^ INV;
            end
            sb[i % 4] = bus.TX_BUSY;
            if (i % 4 == 3) begin
                exp_b = (i >= 7) && (i <= 47);
                chk("stream_busy", 72'(sb), 72'(exp_b ? 4'hF : 4'h0));
                if (exp_b) begin
                    chk("stream_word", rw, mkword(rxi));
                    rxi++;
                end else begin
                    chk("stream_idle", rw, 72'd0);
                end
            end
            if (i < 40 && exp_rdy) acc++;
            step();
        end
        bus.DATA_VALID = 1'b0;

        // Accept in phase 2, second word offered and taken on the phase-3 edge
        step();
        step();
        bus.DATA_VALID = 1'b1;
        bus.DATA_FROM_DEVICE = 72'h11_22_33_44_55_66_77_88_99;
        #1;
        chk("b2b_ready_ph2", 72'(bus.DATA_READY), 72'(1'b1));
        step();
        bus.DATA_FROM_DEVICE = 72'hF0_E1_D2_C3_B4_A5_96_87_78;
        #1;
        chk("b2b_ready_ph3", 72'(bus.DATA_READY), 72'(1'b1));
        step();
        bus.DATA_VALID = 1'b0;
        bus.DATA_FROM_DEVICE = '0;
        #1;
        chk("b2b_ready_ph0", 72'(bus.DATA_READY), 72'(1'b0));
        rx_frame(rw, rb, rf);
        chk("b2b_first",       rw, 72'h11_22_33_44_55_66_77_88_99);
        chk("b2b_first_busy",  72'(rb), 72'(4'hF));
        chk("b2b_first_frame", 72'(rf), 72'(4'b0001));
        rx_frame(rw, rb, rf);
        chk("b2b_second",      rw, 72'hF0_E1_D2_C3_B4_A5_96_87_78);
        chk("b2b_second_busy", 72'(rb), 72'(4'hF));
        rx_frame(rw, rb, rf);
        chk("b2b_idle",        rw, 72'd0);
        chk("b2b_idle_busy",   72'(rb), 72'(4'h0));

        // Reset pulsed at phase 2 of a data frame with a word pending
        step();
        step();
        bus.DATA_VALID = 1'b1;
        bus.DATA_FROM_DEVICE = 72'h0F_1E_2D_3C_4B_5A_69_78_87;
        step();
        bus.DATA_FROM_DEVICE = 72'hDE_AD_BE_EF_01_23_45_67_89;
        step();
        bus.DATA_VALID = 1'b0;
        bus.DATA_FROM_DEVICE = '0;
        step();
        step();
        chk("mid_busy_before", 72'(bus.TX_BUSY), 72'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_ready_in_rst", 72'(bus.DATA_READY), 72'(1'b0));
        step();
        chk("mid_even",  72'(bus.DATA_EVEN),   72'(9'h000));
        chk("mid_odd",   72'(bus.DATA_ODD),    72'(9'h000));
        chk("mid_busy",  72'(bus.TX_BUSY),     72'(1'b0));
        chk("mid_frame", 72'(bus.FRAME_START), 72'(1'b0));
        chk("mid_ready", 72'(bus.DATA_READY),  72'(1'b0));
        rst_n = 1'b1;
        step();
        rx_frame(rw, rb, rf);
        chk("post_rst_word",  rw, 72'd0);
        chk("post_rst_busy",  72'(rb), 72'(4'h0));
        chk("post_rst_frame", 72'(rf), 72'(4'b0001));
        rx_frame(rw, rb, rf);
        chk("post_rst_word2", rw, 72'd0);
        chk("post_rst_busy2", 72'(rb), 72'(4'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
